colour_freq_meter: RTL and testbench
====================================

// Module: colour_freq_meter
// PURPOSE
//  Front end of the colour-sensor path. Drives the sensor filter select through red, green
//  and blue. Counts sensor output-frequency edges over a fixed gate window for each colour.
//  Publishes one RGB count triple per measurement round.
//  Sits upstream of the white-balance stage, which scales these counts into the colours
//  drawn by the VGA display module.
// PARAMETERS
//  GATE_CYCLES    100000  clock cycles per counting window (>=1)
//  SETTLE_CYCLES  1000    clock cycles discarded after each filter switch (>=1)
//  CNT_W          16      width of each colour count
// PORTS
//  clock          in   1      system clock, all logic on rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  start          in   1      request one measurement round; sampled only in IDLE
//  sensor_freq    in   1      asynchronous square wave from the sensor
//  filter_select  out  2      sensor S2:S3 code: 00 red, 11 green, 01 blue
//  count_red      out  CNT_W  rising edges counted in the red window
//  count_green    out  CNT_W  rising edges counted in the green window
//  count_blue     out  CNT_W  rising edges counted in the blue window
//  data_valid     out  1      1-cycle pulse: a new triple is present on count_*
//  overflow       out  1      at least one count of the current triple saturated
//  busy           out  1      round in progress (state != IDLE)
// BEHAVIOUR
//  Reset values:
//   - filter_select=00; count_*=0; data_valid=0; overflow=0; busy=0; state=IDLE.
//   - Synchroniser flops and the edge-detect flop are cleared to 0.
//  Input synchronisation:
//   - sensor_freq passes through a 2-flop synchroniser, then a rising-edge detect
//     (s2 & ~s3), giving a 1-cycle pulse edge_p.
//   - An input edge before clock edge k yields edge_p high in cycle k+2.
//  FSM: IDLE -> SET_R -> GATE_R -> SET_G -> GATE_G -> SET_B -> GATE_B -> IDLE.
//   - IDLE: start=1 at edge k moves to SET_R at k+1 and loads the timer.
//     busy=1 from k+1 onward.
//   - SET_x: filter_select holds the code for x. Lasts exactly SETTLE_CYCLES cycles.
//     edge_p is ignored; the accumulator is cleared.
//   - GATE_x: lasts exactly GATE_CYCLES cycles. Each cycle with edge_p=1 increments
//     the accumulator.
//   - Leaving GATE_x: the accumulator value is latched into a shadow register for x.
//  Saturation and overflow:
//   - The accumulator saturates at 2^CNT_W-1 and never wraps.
//   - A saturating increment sets a round-local overflow flag.
//  Publishing a result:
//   - On the GATE_B -> IDLE edge, count_red, count_green, count_blue and overflow load
//     together, and data_valid=1 for that single cycle.
//   - busy=0 in the same cycle.
//   - Latency: data_valid is high in cycle k+1+3*(SETTLE_CYCLES+GATE_CYCLES).
//  Between rounds:
//   - count_* and overflow hold their values until the next publication.
//   - filter_select returns to 00 in IDLE.
//  Boundary and corner cases:
//   - start while busy=1 is ignored, not queued.
//   - start=1 in the data_valid cycle is accepted, because the FSM is in IDLE that
//     cycle; the next round begins on the following edge.
//   - Edge pulses in the last cycle of GATE_x are counted.
//   - Edge pulses in the first cycle of SET_x are not counted.
//   - Reset asserted mid-round aborts the round. No data_valid is produced and outputs
//     take their reset values.
//   - Timer and counter widths must hold GATE_CYCLES and SETTLE_CYCLES without wrap;
//     derive them with $clog2.
// TESTING  (GATE_CYCLES=100, SETTLE_CYCLES=10, CNT_W=8 unless stated)
//  1. Sensor period 10 clocks, one start pulse:
//     - filter_select steps 00->11->01->00.
//     - count_red=count_green=count_blue=10, overflow=0.
//     - data_valid is a single pulse 331 cycles after start is sampled.
//  2. Sensor periods 5 / 20 / 50 clocks during the R / G / B windows:
//     - counts are 20 / 5 / 2.
//  3. GATE_CYCLES=600, sensor toggles every clock cycle:
//     - count_red=255, overflow=1.
//     - A following round at period 10 gives count_red=60 and overflow=0.
//  4. start re-pulsed during GATE_G:
//     - It is ignored, and exactly one data_valid pulse occurs.
//     - start held high continuously gives back-to-back rounds every 331 cycles.
//  5. reset pulsed during GATE_G:
//     - All outputs go to 0 asynchronously and there is no data_valid.
//     - A later start completes normally.
//  6. Sensor held constant at 0 or 1 through a round:
//     - All counts are 0 and data_valid still pulses.

Source files
------------

// File: rtl/colour_freq_meter.sv
// Colour-sensor front end: steps the filter through red, green and blue, counts sensor
// edges over a fixed gate window per colour and publishes one saturated RGB triple per round.
module colour_freq_meter #(
    parameter int GATE_CYCLES   = 100000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sensor_freq,
    output logic [1:0]       filter_select,
    output logic [CNT_W-1:0] count_red,
    output logic [CNT_W-1:0] count_green,
    output logic [CNT_W-1:0] count_blue,
    output logic             data_valid,
    output logic             overflow,
    output logic             busy
);

    // state  | meaning
    // IDLE   | waiting for start, filter parked on red
    // SET_R  | red filter selected, settling, edges ignored
    // GATE_R | counting edges for red
    // SET_G  | green filter selected, settling
    // GATE_G | counting edges for green
    // SET_B  | blue filter selected, settling
    // GATE_B | counting edges for blue, publishes the triple on exit
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_R  = 3'd1,
        GATE_R = 3'd2,
        SET_G  = 3'd3,
        GATE_G = 3'd4,
        SET_B  = 3'd5,
        GATE_B = 3'd6
    } state_t;

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_GREEN = 2'b11;
    localparam logic [1:0] SEL_BLUE  = 2'b01;

    state_t            state;
    state_t            state_next;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_next;
    logic              tc;

    logic              sync_1;
    logic              sync_2;
    logic              sync_3;
    logic              edge_p;

    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_inc;
    logic              acc_full;
    logic              sat_hit;
    logic              ovf_round;
    logic [CNT_W-1:0]  shadow_red;
    logic [CNT_W-1:0]  shadow_green;

    logic              in_set;
    logic              in_gate;
    logic              publish;

    // Two synchroniser stages, the third flop only feeds the rising-edge detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= sensor_freq;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign edge_p = sync_2 & ~sync_3;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    assign tc = (timer == '0);

    always_comb begin
        state_next    = state;
        timer_next    = tc ? timer : timer - 1'b1;
        filter_select = SEL_RED;
        in_set        = 1'b0;
        in_gate       = 1'b0;
        publish       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SET_R;
                    timer_next = SETTLE_LOAD;
                end
            end
            SET_R: begin
                in_set = 1'b1;
                if (tc) begin
                    state_next = GATE_R;
                    timer_next = GATE_LOAD;
                end
            end
            GATE_R: begin
                in_gate = 1'b1;
                if (tc) begin
                    state_next = SET_G;
                    timer_next = SETTLE_LOAD;
                end
            end
            SET_G: begin
                filter_select = SEL_GREEN;
                in_set        = 1'b1;
                if (tc) begin
                    state_next = GATE_G;
                    timer_next = GATE_LOAD;
                end
            end
            GATE_G: begin
                filter_select = SEL_GREEN;
                in_gate       = 1'b1;
                if (tc) begin
                    state_next = SET_B;
                    timer_next = SETTLE_LOAD;
                end
            end
            SET_B: begin
                filter_select = SEL_BLUE;
                in_set        = 1'b1;
                if (tc) begin
                    state_next = GATE_B;
                    timer_next = GATE_LOAD;
                end
            end
            GATE_B: begin
                filter_select = SEL_BLUE;
                in_gate       = 1'b1;
                if (tc) begin
                    state_next = IDLE;
                    publish    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Saturating increment; an edge arriving at full scale is what flags overflow.
    assign acc_full = (acc == CNT_MAX);
    assign sat_hit  = in_gate & edge_p & acc_full;
    assign acc_inc  = (edge_p && !acc_full) ? acc + 1'b1 : acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            ovf_round    <= 1'b0;
            shadow_red   <= '0;
            shadow_green <= '0;
        end else begin
            if (in_set) begin
                acc <= '0;
            end else if (in_gate) begin
                acc <= acc_inc;
            end

            if (state == IDLE && start) begin
                ovf_round <= 1'b0;
            end else if (sat_hit) begin
                ovf_round <= 1'b1;
            end

            // acc_inc rather than acc so an edge in the final gate cycle is kept.
            if (state == GATE_R && tc) begin
                shadow_red <= acc_inc;
            end
            if (state == GATE_G && tc) begin
                shadow_green <= acc_inc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_red   <= '0;
            count_green <= '0;
            count_blue  <= '0;
            overflow    <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            data_valid <= publish;
            if (publish) begin
                count_red   <= shadow_red;
                count_green <= shadow_green;
                count_blue  <= acc_inc;
                overflow    <= ovf_round | sat_hit;
            end
        end
    end

endmodule

// File: tb/tb_colour_freq_meter.sv
// Self-checking bench for colour_freq_meter: table of per-colour sensor periods with a
// scoreboard of expected triples, plus hand sequences for boundary, start and reset cases.
module tb_colour_freq_meter;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       start_b;
    logic       sensor_freq;

    logic [1:0] filter_select;
    logic [7:0] count_red, count_green, count_blue;
    logic       data_valid, overflow, busy;

    logic [1:0] filter_select_b;
    logic [7:0] count_red_b, count_green_b, count_blue_b;
    logic       data_valid_b, overflow_b, busy_b;

    colour_freq_meter #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .sensor_freq(sensor_freq),
        .filter_select(filter_select), .count_red(count_red), .count_green(count_green),
        .count_blue(count_blue), .data_valid(data_valid), .overflow(overflow), .busy(busy)
    );

    colour_freq_meter #(.GATE_CYCLES(600), .SETTLE_CYCLES(10), .CNT_W(8)) dut_big (
        .clock(clock), .reset(reset), .start(start_b), .sensor_freq(sensor_freq),
        .filter_select(filter_select_b), .count_red(count_red_b), .count_green(count_green_b),
        .count_blue(count_blue_b), .data_valid(data_valid_b), .overflow(overflow_b),
        .busy(busy_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       o;
        int         cyc;
    } exp_t;

    typedef struct {
        int         pr;
        int         pg;
        int         pb;
        logic       hold;
        logic [7:0] er;
        logic [7:0] eg;
        logic [7:0] eb;
    } vec_t;

    exp_t q[$];
    vec_t vecs[6];

    int cyc    = 0;
    int per    = 0;
    int ph     = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    int dv_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (q.size() != 0 && g < 1000) begin
            @(negedge clock);
            g++;
        end
        chk("round_done_pending", q.size(), 0);
    endtask

    task automatic push_exp(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int c);
        exp_t e;
        e.r = r; e.g = g; e.b = b; e.o = 1'b0; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic run_round(input vec_t v);
        int s;
        if (v.pr == 0) begin
            per = 0;
            sensor_freq = v.hold;
        end else begin
            per = v.pr;
        end
        repeat (6) @(negedge clock);
        start = 1'b1;
        s = cyc;
        push_exp(v.er, v.eg, v.eb, s + 331);
        @(negedge clock);
        start = 1'b0;
        wait_cyc(s + 5);
        chk("sel_red", filter_select, 2'b00);
        chk("busy_in_round", busy, 1);
        wait_cyc(s + 111);
        if (v.pr != 0) per = v.pg;
        wait_cyc(s + 115);
        chk("sel_green", filter_select, 2'b11);
        wait_cyc(s + 221);
        if (v.pr != 0) per = v.pb;
        wait_cyc(s + 225);
        chk("sel_blue", filter_select, 2'b01);
        wait_drain();
        @(negedge clock);
        chk("sel_idle", filter_select, 2'b00);
        chk("busy_idle", busy, 0);
    endtask

    task automatic big_round(input int p, input logic [7:0] er, input logic [7:0] eg,
                             input logic [7:0] eb, input logic eo);
        int g = 0;
        per = p;
        repeat (6) @(negedge clock);
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        while (data_valid_b !== 1'b1 && g < 2500) begin
            @(negedge clock);
            g++;
        end
        chk("big_dv_seen", data_valid_b, 1);
        chk("big_red", count_red_b, er);
        chk("big_green", count_green_b, eg);
        chk("big_blue", count_blue_b, eb);
        chk("big_ovf", overflow_b, eo);
        @(negedge clock);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Sensor square wave: one rising edge every per clocks; per=0 leaves the pin to the test.
    initial forever begin
        @(negedge clock);
        if (per != 0) begin
            ph = (ph + 1 >= per) ? 0 : ph + 1;
            sensor_freq = (ph < per / 2);
        end
    end

    initial forever begin
        exp_t e;
        @(posedge clock);
        #1;
        if (data_valid === 1'b1) begin
            dv_cnt++;
            chk("dv_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("count_red", count_red, e.r);
                chk("count_green", count_green, e.g);
                chk("count_blue", count_blue, e.b);
                chk("overflow", overflow, e.o);
                chk("dv_latency", cyc, e.cyc);
                chk("busy_at_dv", busy, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int snap;

        vecs[0] = '{pr: 10, pg: 10, pb: 10, hold: 1'b0, er: 8'd10, eg: 8'd10, eb: 8'd10};
        vecs[1] = '{pr: 5,  pg: 20, pb: 50, hold: 1'b0, er: 8'd20, eg: 8'd5,  eb: 8'd2};
        vecs[2] = '{pr: 20, pg: 5,  pb: 10, hold: 1'b0, er: 8'd5,  eg: 8'd20, eb: 8'd10};
        vecs[3] = '{pr: 0,  pg: 0,  pb: 0,  hold: 1'b0, er: 8'd0,  eg: 8'd0,  eb: 8'd0};
        vecs[4] = '{pr: 0,  pg: 0,  pb: 0,  hold: 1'b1, er: 8'd0,  eg: 8'd0,  eb: 8'd0};
        vecs[5] = '{pr: 25, pg: 4,  pb: 50, hold: 1'b0, er: 8'd4,  eg: 8'd25, eb: 8'd2};

        reset = 1'b1;
        start = 1'b0;
        start_b = 1'b0;
        sensor_freq = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_red", count_red, 0);
        chk("rst_green", count_green, 0);
        chk("rst_blue", count_blue, 0);
        chk("rst_sel", filter_select, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 6; i++) run_round(vecs[i]);

        // Edge landing in the last GATE_R cycle counts; one landing in the first SET_B cycle
        // must count neither for green nor for blue.
        per = 0;
        sensor_freq = 1'b0;
        repeat (6) @(negedge clock);
        start = 1'b1;
        s = cyc;
        push_exp(8'd1, 8'd0, 8'd0, s + 331);
        @(negedge clock);
        start = 1'b0;
        wait_cyc(s + 108);
        sensor_freq = 1'b1;
        wait_cyc(s + 150);
        sensor_freq = 1'b0;
        wait_cyc(s + 219);
        sensor_freq = 1'b1;
        wait_drain();

        // start re-pulsed during GATE_G is dropped
        per = 10;
        repeat (6) @(negedge clock);
        snap = dv_cnt;
        start = 1'b1;
        s = cyc;
        push_exp(8'd10, 8'd10, 8'd10, s + 331);
        @(negedge clock);
        start = 1'b0;
        wait_cyc(s + 150);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_drain();
        wait_cyc(cyc + 400);
        chk("restart_single_dv", dv_cnt - snap, 1);

        // start held high: back-to-back rounds 331 cycles apart
        start = 1'b1;
        s = cyc;
        push_exp(8'd10, 8'd10, 8'd10, s + 331);
        push_exp(8'd10, 8'd10, 8'd10, s + 662);
        wait_cyc(s + 340);
        start = 1'b0;
        wait_drain();
        wait_cyc(cyc + 20);

        // reset mid-round in GATE_G
        start = 1'b1;
        s = cyc;
        @(negedge clock);
        start = 1'b0;
        wait_cyc(s + 150);
        #2 reset = 1'b1;
        #1;
        chk("abort_red", count_red, 0);
        chk("abort_green", count_green, 0);
        chk("abort_blue", count_blue, 0);
        chk("abort_sel", filter_select, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ovf", overflow, 0);
        chk("abort_dv", data_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        snap = dv_cnt;
        wait_cyc(cyc + 400);
        chk("abort_no_dv", dv_cnt - snap, 0);
        run_round(vecs[0]);

        big_round(2, 8'd255, 8'd255, 8'd255, 1'b1);
        big_round(10, 8'd60, 8'd60, 8'd60, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
